// File: rtl/cpu_sequencer.sv
// cpu_sequencer: FSM state register and run control for the 8-bit CPU.
// Holds the architectural state fed to control_unit, applies run / single-step
// control at instruction boundaries, latches halt and fault conditions, and
// counts retired instructions.
// Optional build macro: CPU_SEQ_CYCLE_COUNT_EN builds a saturating counter of
// clocks spent running; without it cycle_count is tied to zero.
module cpu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step_req,
    input  logic [2:0]       next_state,
    input  logic             halt,
    output logic [2:0]       state,
    output logic             running,
    output logic             halted,
    output logic             fault,
    output logic             step_ack,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        FETCH      = 3'b000,
        DECODE     = 3'b001,
        EXECUTE    = 3'b010,
        MEMORY     = 3'b011,
        WRITEBACK  = 3'b100,
        HALT_STATE = 3'b101,
        IDLE       = 3'b110,
        ILLEGAL    = 3'b111
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic             halted_q, halted_d;
    logic             fault_q, fault_d;
    logic             ack_q, ack_d;
    logic             step_mode_q, step_mode_d;
    logic             count_inc;
    logic [CNT_W-1:0] instr_q;

    // State and run-control registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
            ack_q       <= 1'b0;
            step_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            halted_q    <= halted_d;
            fault_q     <= fault_d;
            ack_q       <= ack_d;
            step_mode_q <= step_mode_d;
        end
    end

    // Next-state, sticky flags, step handshake and retire detection
    always_comb begin
        state_d     = state_q;
        halted_d    = halted_q;
        fault_d     = fault_q;
        step_mode_d = step_mode_q;
        count_inc   = 1'b0;
        // The ack drops one edge after the requester releases step_req.
        ack_d       = ack_q && step_req;

        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d     = FETCH;
                    step_mode_d = 1'b0;
                end else if (step_req && !ack_q) begin
                    state_d     = FETCH;
                    step_mode_d = 1'b1;
                end
            end
            FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK: begin
                if (halt || next_state == HALT_STATE) begin
                    // A HALT instruction retires, so it is counted.
                    state_d   = HALT_STATE;
                    halted_d  = 1'b1;
                    count_inc = 1'b1;
                end else if (next_state == IDLE || next_state == ILLEGAL) begin
                    state_d  = HALT_STATE;
                    halted_d = 1'b1;
                    fault_d  = 1'b1;
                end else if (next_state == FETCH && state_q != FETCH) begin
                    // Retire edge: the only point where run/step stop takes effect.
                    count_inc = 1'b1;
                    if (step_mode_q || !run) begin
                        state_d = IDLE;
                        if (step_mode_q) ack_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end else begin
                    state_d = state_t'(next_state);
                end
            end
            HALT_STATE: begin
                state_d = HALT_STATE;
            end
            default: begin
                // Unreachable encoding; park in HALT_STATE and flag it.
                state_d  = HALT_STATE;
                halted_d = 1'b1;
                fault_d  = 1'b1;
            end
        endcase
    end

    // Saturating retired-instruction counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            instr_q <= '0;
        else if (count_inc && instr_q != CNT_MAX)
            instr_q <= instr_q + 1'b1;
    end

    assign state       = state_q;
    assign running     = (state_q <= WRITEBACK);
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign step_ack    = ack_q;
    assign instr_count = instr_q;

`ifdef CPU_SEQ_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cycle_q;

    // Saturating count of edges taken while in FETCH..WRITEBACK
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cycle_q <= '0;
        else if (running && cycle_q != CNT_MAX)
            cycle_q <= cycle_q + 1'b1;
    end

    assign cycle_count = cycle_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: control_unit responses are scripted step by
// step, expected outputs are queued when each step is driven and compared after
// the following clock edge. CNT_W is reduced so counter saturation is reachable.
module tb_cpu_sequencer;

    localparam int CW = 10;
    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3,
                           W = 3'd4, H = 3'd5, I = 3'd6, X = 3'd7;
`ifdef CPU_SEQ_CYCLE_COUNT_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif
    localparam logic [CW-1:0] ALL1 = {CW{1'b1}};

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          run = 1'b0;
    logic          step_req = 1'b0;
    logic [2:0]    next_state = 3'd0;
    logic          halt = 1'b0;
    logic [2:0]    state;
    logic          running, halted, fault, step_ack;
    logic [CW-1:0] instr_count, cycle_count;

    cpu_sequencer #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .run(run), .step_req(step_req),
        .next_state(next_state), .halt(halt), .state(state),
        .running(running), .halted(halted), .fault(fault),
        .step_ack(step_ack), .instr_count(instr_count),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [2:0]    st;
        logic          hl, ft, ak;
        logic [CW-1:0] ic;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(string tag, logic [2:0] st, logic hl, logic ft,
                        logic ak, logic [CW-1:0] ic);
        exp_t e;
        e.tag = tag; e.st = st; e.hl = hl; e.ft = ft; e.ak = ak; e.ic = ic;
        sb.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".state"},   32'(state),       32'(e.st));
        chk({e.tag, ".running"}, 32'(running),     32'(e.st <= W));
        chk({e.tag, ".halted"},  32'(halted),      32'(e.hl));
        chk({e.tag, ".fault"},   32'(fault),       32'(e.ft));
        chk({e.tag, ".ack"},     32'(step_ack),    32'(e.ak));
        chk({e.tag, ".icnt"},    32'(instr_count), 32'(e.ic));
    endtask

    task automatic cyc(logic [2:0] ns, logic h);
        next_state = ns;
        halt = h;
        @(posedge clk);
        #1;
    endtask

    // Drive one control_unit response, expect the post-edge outputs.
    task automatic stepx(string tag, logic [2:0] ns, logic h, logic [2:0] st,
                         logic hl, logic ft, logic ak, logic [CW-1:0] ic);
        push(tag, st, hl, ft, ak, ic);
        cyc(ns, h);
        pop_compare();
    endtask

    task automatic chk_cyc(string tag, logic [CW-1:0] v);
        chk(tag, 32'(cycle_count), CYC_EN ? 32'(v) : 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        push("reset", I, 0, 0, 0, '0);
        pop_compare();
        chk_cyc("reset.cyc", '0);
        @(posedge clk); #1 reset = 1'b1;

        // Free run, three F,D,E,W instructions; run dropped before the last retire
        run = 1'b1;
        stepx("t2_go", F, 0, F, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            stepx("t2_d", D, 0, D, 0, 0, 0, CW'(k));
            stepx("t2_e", E, 0, E, 0, 0, 0, CW'(k));
            stepx("t2_w", W, 0, W, 0, 0, 0, CW'(k));
            if (k == 2) run = 1'b0;
            stepx("t2_ret", F, 0, (k == 2) ? I : F, 0, 0, 0, CW'(k + 1));
        end
        chk_cyc("t2.cyc", 12);

        // run dropped in DECODE: instruction completes, IDLE at retire, no ack
        run = 1'b1;
        stepx("t4_go", F, 0, F, 0, 0, 0, 3);
        stepx("t4_d", D, 0, D, 0, 0, 0, 3);
        run = 1'b0;
        stepx("t4_e", E, 0, E, 0, 0, 0, 3);
        stepx("t4_w", W, 0, W, 0, 0, 0, 3);
        stepx("t4_ret", F, 0, I, 0, 0, 0, 4);
        stepx("t4_idle", F, 0, I, 0, 0, 0, 4);
        chk_cyc("t4.cyc", 16);

        // Single step with 4-phase handshake
        step_req = 1'b1;
        stepx("t3_go", F, 0, F, 0, 0, 0, 4);
        stepx("t3_d", D, 0, D, 0, 0, 0, 4);
        stepx("t3_e", E, 0, E, 0, 0, 0, 4);
        stepx("t3_w", W, 0, W, 0, 0, 0, 4);
        stepx("t3_ret", F, 0, I, 0, 0, 1, 5);
        stepx("t3_hold1", F, 0, I, 0, 0, 1, 5);
        stepx("t3_hold2", F, 0, I, 0, 0, 1, 5);
        step_req = 1'b0;
        stepx("t3_clr", F, 0, I, 0, 0, 0, 5);
        stepx("t3_idle", F, 0, I, 0, 0, 0, 5);
        chk_cyc("t3.cyc", 20);

        // Asynchronous reset mid-EXECUTE
        run = 1'b1;
        stepx("t1_go", F, 0, F, 0, 0, 0, 5);
        stepx("t1_d", D, 0, D, 0, 0, 0, 5);
        stepx("t1_e", E, 0, E, 0, 0, 0, 5);
        #2 reset = 1'b0;
        #1;
        push("t1_async", I, 0, 0, 0, '0);
        pop_compare();
        chk_cyc("t1.cyc", '0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Illegal next_state in DECODE -> fault, no count
        stepx("t6_go", F, 0, F, 0, 0, 0, 0);
        stepx("t6_d", D, 0, D, 0, 0, 0, 0);
        stepx("t6_bad", X, 0, H, 1, 1, 0, 0);
        stepx("t6_stay", F, 0, H, 1, 1, 0, 0);

        // Async reset pulse between edges, then halt in EXECUTE
        #2 reset = 1'b0;
        #1 reset = 1'b1;
        push("t5_rst", I, 0, 0, 0, '0);
        pop_compare();
        stepx("t5_go", F, 0, F, 0, 0, 0, 0);
        stepx("t5_d", D, 0, D, 0, 0, 0, 0);
        stepx("t5_e", E, 0, E, 0, 0, 0, 0);
        stepx("t5_halt", M, 1, H, 1, 0, 0, 1);
        step_req = 1'b1;
        for (int k = 0; k < 10; k++)
            stepx("t5_absorb", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  H, 1, 0, 0, 1);

        // Counter saturation
        step_req = 1'b0;
        #2 reset = 1'b0;
        #1 reset = 1'b1;
        stepx("t7_go", F, 0, F, 0, 0, 0, 0);
        for (int k = 0; k < int'(ALL1); k++) begin
            cyc(D, 0);
            cyc(F, 0);
        end
        push("t7_full", F, 0, 0, 0, ALL1);
        pop_compare();
        stepx("t7_d", D, 0, D, 0, 0, 0, ALL1);
        stepx("t7_sat", F, 0, F, 0, 0, 0, ALL1);
        chk_cyc("t7.cyc_sat", ALL1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
